// File: rtl/mem_stage_pkg.sv
// Memory stage shared definitions: opcodes, byte enables,
// FSM encoding and opcode classification helpers.
package mem_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [5:0] OP_NOP = 6'h00;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2b;
  localparam logic [5:0] OP_LD  = 6'h37;
  localparam logic [5:0] OP_SD  = 6'h3f;

  localparam logic [XLEN-1:0] NOP_WORD = {OP_NOP, 26'b0};

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_LO   = 4'b0011;
  localparam logic [3:0] BE_HI   = 4'b1100;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC1 = 2'd1,
    ACC2 = 2'd2
  } state_t;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LD);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SD);
  endfunction

  function automatic logic is_mem(input logic [5:0] op);
    return is_load(op) || is_store(op);
  endfunction

  function automatic logic is_half(input logic [5:0] op);
    return (op == OP_LH) || (op == OP_SH);
  endfunction

  function automatic logic is_double(input logic [5:0] op);
    return (op == OP_LD) || (op == OP_SD);
  endfunction

  function automatic logic misaligned(
    input logic [5:0] op,
    input logic [2:0] a
  );
    logic [2:0] m;
    if (is_double(op))    m = 3'b111;
    else if (is_half(op)) m = 3'b001;
    else                  m = 3'b011;
    return |(a & m);
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data lane select: word pass-through or
// sign-extended halfword picked by address bit 1.
module mem_load_align #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rdata,
  input  logic             half,
  input  logic             hi,
  output logic [WIDTH-1:0] data
);

  logic [15:0] lane;

  assign lane = hi ? rdata[31:16] : rdata[15:0];
  assign data = half ? {{(WIDTH-16){lane[15]}}, lane} : rdata;

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: req/ack data-memory access for
// LW/LH/LD/SW/SH/SD, pass-through for everything else.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int               WIDTH  = XLEN,
  parameter logic [WIDTH-1:0] NOP_IR = NOP_WORD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   IR_in,
  input  logic [WIDTH-3:0]   PC_in,
  input  logic [WIDTH-1:0]   Z_in,
  input  logic [2*WIDTH-1:0] SD_in,
  output logic [WIDTH-1:0]   IR_out,
  output logic [WIDTH-3:0]   PC_out,
  output logic [WIDTH-1:0]   Z_out,
  output logic [WIDTH-1:0]   Z2_out,
  output logic               IsStall,
  output logic               AddrErr,
  output logic               mem_req,
  output logic               mem_we,
  output logic [WIDTH-1:0]   mem_addr,
  output logic [3:0]         mem_be,
  output logic [WIDTH-1:0]   mem_wdata,
  input  logic [WIDTH-1:0]   mem_rdata,
  input  logic               mem_ack
);

  state_t state, state_nx;

  logic [WIDTH-1:0]   ir_q, addr_q, word0_q;
  logic [WIDTH-3:0]   pc_q;
  logic [2*WIDTH-1:0] sd_q;

  logic [WIDTH-1:0]   cur_ir, cur_z, acc_addr, ld_data;
  logic [WIDTH-3:0]   cur_pc;
  logic [2*WIDTH-1:0] cur_sd;
  logic [5:0]         op;
  logic               idle, second, last;
  logic               bad, go, req, ack, done;

  // In IDLE the live inputs drive the access; afterwards only the latched copy.
  assign idle   = (state == IDLE);
  assign cur_ir = idle ? IR_in : ir_q;
  assign cur_pc = idle ? PC_in : pc_q;
  assign cur_z  = idle ? Z_in  : addr_q;
  assign cur_sd = idle ? SD_in : sd_q;
  assign op     = cur_ir[WIDTH-1 -: 6];

  assign second = (state == ACC2);
  assign last   = !is_double(op) || second;
  assign bad    = idle && is_mem(op) && misaligned(op, cur_z[2:0]);
  assign go     = is_mem(op) && !bad;
  assign req    = go && !rst;
  assign ack    = req && mem_ack;
  assign done   = ack && last;

  assign acc_addr = cur_z + {{(WIDTH-3){1'b0}}, second, 2'b00};

  mem_load_align #(
    .WIDTH (WIDTH)
  ) u_align (
    .rdata (mem_rdata),
    .half  (is_half(op)),
    .hi    (cur_z[1]),
    .data  (ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (go)  state_nx = ack ? (last ? IDLE : ACC2) : ACC1;
      ACC1: if (ack) state_nx = last ? IDLE : ACC2;
      ACC2: if (ack) state_nx = IDLE;
      default:       state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = BE_NONE;
    mem_wdata = '0;
    IsStall   = req && !done;
    if (req) begin
      mem_req  = 1'b1;
      mem_we   = is_store(op);
      mem_addr = {acc_addr[WIDTH-1:2], 2'b00};
      if (is_half(op)) mem_be = cur_z[1] ? BE_HI : BE_LO;
      else             mem_be = BE_WORD;
      if (is_store(op)) begin
        if (is_half(op))  mem_wdata = {2{cur_sd[15:0]}};
        else if (second)  mem_wdata = cur_sd[2*WIDTH-1:WIDTH];
        else              mem_wdata = cur_sd[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q    <= NOP_IR;
      pc_q    <= '0;
      addr_q  <= '0;
      sd_q    <= '0;
      word0_q <= '0;
      IR_out  <= NOP_IR;
      PC_out  <= '0;
      Z_out   <= '0;
      Z2_out  <= '0;
      AddrErr <= 1'b0;
    end else begin
      AddrErr <= bad;
      if (idle) begin
        ir_q   <= IR_in;
        pc_q   <= PC_in;
        addr_q <= Z_in;
        sd_q   <= SD_in;
      end
      if (ack && !last) word0_q <= mem_rdata;
      if (done) begin
        IR_out <= cur_ir;
        PC_out <= cur_pc;
        if (is_store(op))      Z_out <= cur_z;
        else if (is_double(op)) Z_out <= word0_q;
        else                   Z_out <= ld_data;
        Z2_out <= (is_double(op) && !is_store(op)) ? mem_rdata : '0;
      end else if (go) begin
        IR_out <= NOP_IR;
        Z_out  <= '0;
        Z2_out <= '0;
      end else if (bad) begin
        IR_out <= NOP_IR;
        PC_out <= PC_in;
        Z_out  <= '0;
        Z2_out <= '0;
      end else begin
        IR_out <= IR_in;
        PC_out <= PC_in;
        Z_out  <= Z_in;
        Z2_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage against a
// transaction-level model of each instruction.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int W = 32;
  localparam logic [5:0] OP_ADD = 6'h08;
  localparam logic [5:0] OP_UNK = 6'h3a;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   IR_in, Z_in, IR_out, Z_out, Z2_out;
  logic [W-3:0]   PC_in, PC_out;
  logic [2*W-1:0] SD_in;
  logic           IsStall, AddrErr;
  logic           mem_req, mem_we, mem_ack;
  logic [W-1:0]   mem_addr, mem_wdata, mem_rdata;
  logic [3:0]     mem_be;

  int checks = 0;
  int failures = 0;

  mem_stage dut (
    .clk       (clk),
    .rst       (rst),
    .IR_in     (IR_in),
    .PC_in     (PC_in),
    .Z_in      (Z_in),
    .SD_in     (SD_in),
    .IR_out    (IR_out),
    .PC_out    (PC_out),
    .Z_out     (Z_out),
    .Z2_out    (Z2_out),
    .IsStall   (IsStall),
    .AddrErr   (AddrErr),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one instruction and serve its memory accesses.
  // Entered and left 2 time units after a rising edge.
  task automatic run(
    input logic [5:0]  op,
    input logic [31:0] z,
    input logic [63:0] sd,
    input int          dly,
    input logic [31:0] rdv,
    input bit          rfix
  );
    logic [31:0] ir, a, wd, ez, ez2;
    logic [31:0] rd [2];
    logic [29:0] pc;
    logic [15:0] hw;
    logic [3:0]  be;
    logic [2:0]  mask;
    bit          memop, st, dbl, hf, bad;
    int          n, d;
    ir    = {op, 26'($urandom)};
    pc    = 30'($urandom);
    st    = (op == OP_SW) || (op == OP_SH) || (op == OP_SD);
    dbl   = (op == OP_LD) || (op == OP_SD);
    hf    = (op == OP_LH) || (op == OP_SH);
    memop = st || (op == OP_LW) || (op == OP_LH) || (op == OP_LD);
    mask  = dbl ? 3'd7 : (hf ? 3'd1 : 3'd3);
    bad   = memop && ((z[2:0] & mask) != 3'd0);
    n     = (!memop || bad) ? 0 : (dbl ? 2 : 1);
    IR_in = ir;
    PC_in = pc;
    Z_in  = z;
    SD_in = sd;
    mem_ack = 1'b0;
    #1;
    if (n == 0) begin
      check("req_none", mem_req, 0);
      check("stall_none", IsStall, 0);
      @(posedge clk);
      #1;
      check("ir_pass", IR_out, bad ? NOP_WORD : ir);
      check("z_pass", Z_out, bad ? 32'd0 : z);
      check("z2_pass", Z2_out, 0);
      check("addrerr", AddrErr, bad);
      if (!bad) check("pc_pass", PC_out, pc);
      #1;
      return;
    end
    for (int k = 0; k < n; k++) begin
      a  = {z[31:2], 2'b00} + 32'(4 * k);
      be = hf ? (z[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      if (!st)      wd = 32'd0;
      else if (hf)  wd = {2{sd[15:0]}};
      else          wd = (k == 0) ? sd[31:0] : sd[63:32];
      d = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
      for (int c = 0; c <= d; c++) begin
        check("req", mem_req, 1);
        check("addr", mem_addr, a);
        check("we", mem_we, st);
        check("be", mem_be, be);
        if (st) check("wdata", mem_wdata, wd);
        if (c == d) begin
          rd[k] = rfix ? rdv : $urandom;
          mem_rdata = rd[k];
          mem_ack = 1'b1;
          #1;
          check("stall_ack", IsStall, (k < n - 1));
        end else begin
          check("stall_wait", IsStall, 1);
        end
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        mem_rdata = '0;
        if (k < n - 1 || c < d) begin
          check("bubble_ir", IR_out, NOP_WORD);
          check("bubble_z", Z_out, 0);
          check("bubble_z2", Z2_out, 0);
        end
        #1;
      end
    end
    ez2 = 32'd0;
    if (st) begin
      ez = z;
    end else if (hf) begin
      hw = z[1] ? rd[0][31:16] : rd[0][15:0];
      ez = 32'($signed(hw));
    end else begin
      ez = rd[0];
      if (dbl) ez2 = rd[1];
    end
    check("done_ir", IR_out, ir);
    check("done_pc", PC_out, pc);
    check("done_z", Z_out, ez);
    check("done_z2", Z2_out, ez2);
    check("done_err", AddrErr, 0);
  endtask

  logic [5:0] ops [9];
  logic [5:0] rop;
  logic [31:0] rz;
  logic [2:0]  rmask;

  initial begin
    ops = '{OP_ADD, OP_UNK, OP_NOP, OP_LW, OP_LH,
            OP_LD, OP_SW, OP_SH, OP_SD};
    rst = 1'b1;
    IR_in = NOP_WORD;
    PC_in = '0;
    Z_in = '0;
    SD_in = '0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ir", IR_out, NOP_WORD);
    check("rst_pc", PC_out, 0);
    check("rst_z", Z_out, 0);
    check("rst_z2", Z2_out, 0);
    check("rst_stall", IsStall, 0);
    check("rst_err", AddrErr, 0);
    check("rst_req", mem_req, 0);
    check("rst_mem", {mem_we, mem_addr, mem_be, mem_wdata}, 0);
    rst = 1'b0;
    #1;

    run(OP_ADD, 32'h5, 64'h0, 0, 32'h0, 1'b0);
    check("add_z5", Z_out, 32'h5);
    run(OP_LW, 32'h100, 64'h0, 2, 32'hdead_beef, 1'b1);
    check("lw_data", Z_out, 32'hdead_beef);
    run(OP_LH, 32'h102, 64'h0, 1, 32'h8001_1234, 1'b1);
    check("lh_data", Z_out, 32'hffff_8001);
    run(OP_SD, 32'h200, 64'h1111_2222_3333_4444, 0, 32'h0, 1'b0);
    run(OP_LW, 32'h103, 64'h0, 0, 32'h0, 1'b0);
    run(OP_SH, 32'h3fe, 64'h0000_0000_0000_abcd, 1, 32'h0, 1'b0);
    run(OP_LD, 32'h408, 64'h0, 1, 32'h0, 1'b0);

    // LD at top of memory, reset while second word outstanding
    IR_in = {OP_LD, 26'h0};
    PC_in = 30'h123;
    Z_in = 32'hffff_fff8;
    mem_ack = 1'b1;
    mem_rdata = $urandom;
    #1;
    check("ldr_req0", mem_req, 1);
    check("ldr_addr0", mem_addr, 32'hffff_fff8);
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    #1;
    check("ldr_req1", mem_req, 1);
    check("ldr_addr1", mem_addr, 32'hffff_fffc);
    rst = 1'b1;
    #1;
    check("ldr_req_rst", mem_req, 0);
    check("ldr_stall_rst", IsStall, 0);
    check("ldr_ir_rst", IR_out, NOP_WORD);
    check("ldr_pc_rst", PC_out, 0);
    check("ldr_z_rst", {Z_out, Z2_out}, 0);
    check("ldr_mem_rst", {mem_we, mem_addr, mem_be, mem_wdata}, 0);
    IR_in = {OP_ADD, 26'h15};
    PC_in = 30'h77;
    Z_in = 32'h7;
    mem_ack = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("late_ack_req", mem_req, 0);
    check("late_ack_stall", IsStall, 0);
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    check("post_rst_ir", IR_out, {OP_ADD, 26'h15});
    check("post_rst_z", Z_out, 32'h7);
    check("post_rst_pc", PC_out, 30'h77);
    #1;

    for (int i = 0; i < 120; i++) begin
      rop = ops[$urandom_range(0, 8)];
      rz = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        rmask = (rop == OP_LD || rop == OP_SD) ? 3'd7 :
                (rop == OP_LH || rop == OP_SH) ? 3'd1 : 3'd3;
        rz[2:0] = rz[2:0] & ~rmask;
      end
      run(rop, rz, {$urandom, $urandom}, -1, 32'h0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
